// File: rtl/demux2_pkg.sv
// ----------------------------------------------------------------------------
// demux2_pkg
// Shared constants and sizing helpers for the buffered 1-to-2 stream router.
//   ptr_width(depth) : FIFO read/write pointer width, clog2(depth)
//   cnt_width(depth) : FIFO occupancy count width, one bit wider than the
//                      pointer so that a full FIFO (count == depth) fits
//   SEL_OUT0/SEL_OUT1: in_sel encodings for the two destinations
// ----------------------------------------------------------------------------
package demux2_pkg;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_nbits.sv
// ----------------------------------------------------------------------------
// fifo_nbits
// Small synchronous FIFO with val/rdy handshakes on both sides.
// p_depth must be a power of two and at least 2 so that pointers wrap for
// free when they overflow.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low; clears pointers and count only
//   enq_val  : producer has a message
//   enq_rdy  : FIFO not full
//   enq_msg  : message written at the tail on an enqueue
//   deq_val  : FIFO not empty
//   deq_rdy  : consumer takes the head this cycle
//   deq_msg  : message at the head (meaningless while deq_val is low)
// ----------------------------------------------------------------------------
module fifo_nbits
    import demux2_pkg::*;
#(
    parameter int p_nbits = 32,
    parameter int p_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg
);

    localparam int PTR_W = ptr_width(p_depth);
    localparam int CNT_W = cnt_width(p_depth);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(p_depth);

    logic [p_nbits-1:0] mem_q [p_depth];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic full;
    logic empty;
    logic enq_fire;
    logic deq_fire;

    // Full is judged on the registered count only: a dequeue in the same
    // cycle does not open a slot for an enqueue until the next cycle.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign enq_rdy  = !full;
    assign deq_val  = !empty;
    assign enq_fire = enq_val && !full;
    assign deq_fire = deq_rdy && !empty;
    assign deq_msg  = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_fire) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (deq_fire) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers decide
    // what is visible.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_q[tail_q] <= enq_msg;
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (!reset)
        count_q <= CNT_FULL);

    ptrs_track_count: assert property (@(posedge clk) disable iff (!reset)
        (tail_q - head_q) == PTR_W'(count_q));

endmodule

// File: rtl/demux2_buffered.sv
// ----------------------------------------------------------------------------
// demux2_buffered
// 1-to-2 stream router. Each accepted input message is steered by in_sel into
// one of two independent output FIFOs, so a stalled consumer only backs up
// its own side. Latency is one cycle; there is no bypass from in_msg to the
// outputs.
//   clk              : rising-edge clock
//   reset            : asynchronous, active-low; empties both FIFOs
//   in_val/in_rdy    : input handshake; in_rdy reflects the FIFO picked by
//                      in_sel and does not depend on in_val
//   in_sel           : 0 -> out0, 1 -> out1
//   in_msg           : input message
//   out0_val/rdy/msg : head of the out0 FIFO
//   out1_val/rdy/msg : head of the out1 FIFO
// ----------------------------------------------------------------------------
module demux2_buffered
    import demux2_pkg::*;
#(
    parameter int p_nbits = 32,
    parameter int p_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic               in_sel,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out0_val,
    input  logic               out0_rdy,
    output logic [p_nbits-1:0] out0_msg,
    output logic               out1_val,
    input  logic               out1_rdy,
    output logic [p_nbits-1:0] out1_msg
);

    logic enq0_val;
    logic enq1_val;
    logic enq0_rdy;
    logic enq1_rdy;

    assign enq0_val = in_val && (in_sel == SEL_OUT0);
    assign enq1_val = in_val && (in_sel == SEL_OUT1);
    assign in_rdy   = (in_sel == SEL_OUT1) ? enq1_rdy : enq0_rdy;

    fifo_nbits #(
        .p_nbits (p_nbits),
        .p_depth (p_depth)
    ) u_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq0_val),
        .enq_rdy (enq0_rdy),
        .enq_msg (in_msg),
        .deq_val (out0_val),
        .deq_rdy (out0_rdy),
        .deq_msg (out0_msg)
    );

    fifo_nbits #(
        .p_nbits (p_nbits),
        .p_depth (p_depth)
    ) u_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq1_val),
        .enq_rdy (enq1_rdy),
        .enq_msg (in_msg),
        .deq_val (out1_val),
        .deq_rdy (out1_rdy),
        .deq_msg (out1_msg)
    );

endmodule

// File: tb/tb_demux2_buffered.sv
// ----------------------------------------------------------------------------
// tb_demux2_buffered
// Directed checks on a 32-bit, depth-2 router, then a random run that drives
// that instance and a 1-bit, depth-4 instance side by side against queue
// models of each output.
// ----------------------------------------------------------------------------
module tb_demux2_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_in_val, a_in_rdy, a_in_sel;
    logic [31:0] a_in_msg;
    logic        a_out0_val, a_out0_rdy;
    logic [31:0] a_out0_msg;
    logic        a_out1_val, a_out1_rdy;
    logic [31:0] a_out1_msg;

    logic        b_in_val, b_in_rdy, b_in_sel;
    logic [0:0]  b_in_msg;
    logic        b_out0_val, b_out0_rdy;
    logic [0:0]  b_out0_msg;
    logic        b_out1_val, b_out1_rdy;
    logic [0:0]  b_out1_msg;

    demux2_buffered #(.p_nbits(32), .p_depth(2)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .in_val   (a_in_val),
        .in_rdy   (a_in_rdy),
        .in_sel   (a_in_sel),
        .in_msg   (a_in_msg),
        .out0_val (a_out0_val),
        .out0_rdy (a_out0_rdy),
        .out0_msg (a_out0_msg),
        .out1_val (a_out1_val),
        .out1_rdy (a_out1_rdy),
        .out1_msg (a_out1_msg)
    );

    demux2_buffered #(.p_nbits(1), .p_depth(4)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .in_val   (b_in_val),
        .in_rdy   (b_in_rdy),
        .in_sel   (b_in_sel),
        .in_msg   (b_in_msg),
        .out0_val (b_out0_val),
        .out0_rdy (b_out0_rdy),
        .out0_msg (b_out0_msg),
        .out1_val (b_out1_val),
        .out1_rdy (b_out1_rdy),
        .out1_msg (b_out1_msg)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] qa0[$];
    logic [31:0] qa1[$];
    logic [31:0] qb0[$];
    logic [31:0] qb1[$];

    int   sent;
    int   recv;
    logic acc;
    logic exp_rdy_a, exp_rdy_b;
    logic enq_a, enq_b, deq_a0, deq_a1, deq_b0, deq_b1;
    logic sel_a, sel_b;
    logic [31:0] msg_a, msg_b;

    initial begin
        reset      = 1'b0;
        a_in_val   = 1'b0; a_in_sel = 1'b0; a_in_msg = '0;
        a_out0_rdy = 1'b0; a_out1_rdy = 1'b0;
        b_in_val   = 1'b0; b_in_sel = 1'b0; b_in_msg = '0;
        b_out0_rdy = 1'b0; b_out1_rdy = 1'b0;

        // ---- reset state ----
        #12;
        check_val("rst_in_rdy", a_in_rdy, 1);
        check_val("rst_out0_val", a_out0_val, 0);
        check_val("rst_out1_val", a_out1_val, 0);
        reset = 1'b1;
        tick();
        check_val("post_rst_in_rdy", a_in_rdy, 1);
        check_val("post_rst_out0_val", a_out0_val, 0);
        check_val("post_rst_out1_val", a_out1_val, 0);

        // ---- basic ----
        a_in_val = 1'b1; a_in_sel = 1'b0; a_in_msg = 32'h0000_0190;
        tick();
        a_in_val = 1'b0;
        #1;
        check_val("basic_out0_val", a_out0_val, 1);
        check_val("basic_out0_msg", a_out0_msg, 32'h190);
        check_val("basic_out1_val", a_out1_val, 0);
        a_out0_rdy = 1'b1;
        tick();
        check_val("basic_drained", a_out0_val, 0);

        // ---- routing ----
        a_out0_rdy = 1'b1; a_out1_rdy = 1'b1;
        a_in_val = 1'b1; a_in_sel = 1'b1; a_in_msg = 32'hA;
        tick();
        check_val("route_a_val", a_out1_val, 1);
        check_val("route_a_msg", a_out1_msg, 32'hA);
        check_val("route_a_out0", a_out0_val, 0);
        a_in_sel = 1'b0; a_in_msg = 32'hB;
        tick();
        check_val("route_b_val", a_out0_val, 1);
        check_val("route_b_msg", a_out0_msg, 32'hB);
        check_val("route_b_out1", a_out1_val, 0);
        a_in_sel = 1'b1; a_in_msg = 32'hC;
        tick();
        check_val("route_c_val", a_out1_val, 1);
        check_val("route_c_msg", a_out1_msg, 32'hC);
        check_val("route_c_out0", a_out0_val, 0);
        a_in_val = 1'b0;
        tick();
        check_val("route_idle_out0", a_out0_val, 0);
        check_val("route_idle_out1", a_out1_val, 0);

        // ---- full / backpressure ----
        a_out0_rdy = 1'b0; a_out1_rdy = 1'b0;
        a_in_val = 1'b1; a_in_sel = 1'b1; a_in_msg = 32'h1;
        tick();
        a_in_msg = 32'h2;
        tick();
        a_in_msg = 32'h99;
        #1;
        check_val("full_in_rdy", a_in_rdy, 0);
        tick();
        check_val("full_stall_in_rdy", a_in_rdy, 0);
        check_val("full_head_msg", a_out1_msg, 32'h1);
        a_in_sel = 1'b0; a_in_msg = 32'h3;
        #1;
        check_val("other_side_rdy", a_in_rdy, 1);
        tick();
        a_in_val = 1'b0; a_in_sel = 1'b1;
        a_out1_rdy = 1'b1; a_out0_rdy = 1'b1;
        #1;
        check_val("side0_val", a_out0_val, 1);
        check_val("side0_msg", a_out0_msg, 32'h3);
        check_val("full_while_deq_rdy", a_in_rdy, 0);
        tick();
        check_val("drain_msg2", a_out1_msg, 32'h2);
        check_val("drain_in_rdy_back", a_in_rdy, 1);
        check_val("side0_drained", a_out0_val, 0);
        tick();
        check_val("drain_out1_empty", a_out1_val, 0);
        a_out0_rdy = 1'b0; a_out1_rdy = 1'b0;

        // ---- wrap-around ----
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            a_in_sel   = 1'b0;
            a_in_val   = (sent < 10);
            a_in_msg   = 32'(sent);
            a_out0_rdy = (cyc % 2 == 0);
            #1;
            acc = a_in_val && a_in_rdy;
            if (a_out0_val && a_out0_rdy) begin
                check_val("wrap_order", a_out0_msg, 32'(recv));
                recv++;
            end
            tick();
            if (acc) sent++;
        end
        a_in_val = 1'b0; a_out0_rdy = 1'b0;
        check_val("wrap_count", 32'(recv), 10);
        check_val("wrap_empty", a_out0_val, 0);

        // ---- reset mid-operation ----
        a_in_val = 1'b1; a_in_sel = 1'b0; a_in_msg = 32'h11;
        tick();
        a_in_msg = 32'h22;
        tick();
        a_in_sel = 1'b1; a_in_msg = 32'h33;
        tick();
        a_in_val = 1'b0; a_in_sel = 1'b0;
        check_val("pre_rst_out0_val", a_out0_val, 1);
        check_val("pre_rst_out1_val", a_out1_val, 1);
        #3;
        reset = 1'b0;
        #1;
        check_val("async_rst_out0_val", a_out0_val, 0);
        check_val("async_rst_out1_val", a_out1_val, 0);
        check_val("async_rst_rdy_sel0", a_in_rdy, 1);
        a_in_sel = 1'b1;
        #1;
        check_val("async_rst_rdy_sel1", a_in_rdy, 1);
        tick();
        reset = 1'b1;
        a_in_val = 1'b1; a_in_sel = 1'b1; a_in_msg = 32'h44;
        tick();
        a_in_val = 1'b0;
        #1;
        check_val("after_rst_out1_val", a_out1_val, 1);
        check_val("after_rst_out1_msg", a_out1_msg, 32'h44);
        check_val("after_rst_out0_val", a_out0_val, 0);
        a_out1_rdy = 1'b1;
        tick();
        check_val("after_rst_alone", a_out1_val, 0);
        a_out1_rdy = 1'b0;

        // ---- random, both instances ----
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            a_in_val   = 1'($urandom_range(0, 1));
            a_in_sel   = 1'($urandom_range(0, 1));
            a_in_msg   = $urandom();
            a_out0_rdy = 1'($urandom_range(0, 1));
            a_out1_rdy = 1'($urandom_range(0, 1));
            b_in_val   = 1'($urandom_range(0, 1));
            b_in_sel   = 1'($urandom_range(0, 1));
            b_in_msg   = 1'($urandom_range(0, 1));
            b_out0_rdy = 1'($urandom_range(0, 1));
            b_out1_rdy = 1'($urandom_range(0, 1));
            #1;
            exp_rdy_a = (a_in_sel ? qa1.size() : qa0.size()) < 2;
            exp_rdy_b = (b_in_sel ? qb1.size() : qb0.size()) < 4;
            check_val("rnd_a_in_rdy", a_in_rdy, exp_rdy_a);
            check_val("rnd_a_out0_val", a_out0_val, qa0.size() != 0);
            check_val("rnd_a_out1_val", a_out1_val, qa1.size() != 0);
            if (qa0.size() != 0) check_val("rnd_a_out0_msg", a_out0_msg, qa0[0]);
            if (qa1.size() != 0) check_val("rnd_a_out1_msg", a_out1_msg, qa1[0]);
            check_val("rnd_b_in_rdy", b_in_rdy, exp_rdy_b);
            check_val("rnd_b_out0_val", b_out0_val, qb0.size() != 0);
            check_val("rnd_b_out1_val", b_out1_val, qb1.size() != 0);
            if (qb0.size() != 0) check_val("rnd_b_out0_msg", 32'(b_out0_msg), qb0[0]);
            if (qb1.size() != 0) check_val("rnd_b_out1_msg", 32'(b_out1_msg), qb1[0]);

            enq_a  = a_in_val && exp_rdy_a;
            enq_b  = b_in_val && exp_rdy_b;
            deq_a0 = (qa0.size() != 0) && a_out0_rdy;
            deq_a1 = (qa1.size() != 0) && a_out1_rdy;
            deq_b0 = (qb0.size() != 0) && b_out0_rdy;
            deq_b1 = (qb1.size() != 0) && b_out1_rdy;
            sel_a  = a_in_sel;
            sel_b  = b_in_sel;
            msg_a  = a_in_msg;
            msg_b  = 32'(b_in_msg);
            tick();
            if (deq_a0) void'(qa0.pop_front());
            if (deq_a1) void'(qa1.pop_front());
            if (deq_b0) void'(qb0.pop_front());
            if (deq_b1) void'(qb1.pop_front());
            if (enq_a) begin
                if (sel_a) qa1.push_back(msg_a);
                else       qa0.push_back(msg_a);
            end
            if (enq_b) begin
                if (sel_b) qb1.push_back(msg_b);
                else       qb0.push_back(msg_b);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
